// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: write-port requester, hazard and register-file signals for rf_write_arbiter
interface rf_write_arbiter_if;
    logic        wb_en_a;
    logic [3:0]  dest_a;
    logic [31:0] result_a;
    logic        valid_b;
    logic [3:0]  dest_b;
    logic [31:0] result_b;
    logic        ready_b;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        pend_hit1;
    logic        pend_hit2;
    logic        stall_req;
    logic        writeBackEn;
    logic [3:0]  Dest_wb;
    logic [31:0] Result_WB;
    modport master (
        output wb_en_a, dest_a, result_a, valid_b, dest_b, result_b, src1, src2,
        input  ready_b, pend_hit1, pend_hit2, stall_req, writeBackEn, Dest_wb, Result_WB
    );
    modport slave (
        input  wb_en_a, dest_a, result_a, valid_b, dest_b, result_b, src1, src2,
        output ready_b, pend_hit1, pend_hit2, stall_req, writeBackEn, Dest_wb, Result_WB
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the RF write port between pipeline WB (A) and a FIFO-buffered slow unit (B); RF_ARB_BYPASS_EN adds same-cycle B bypass
module rf_write_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input logic clk,
    input logic rst,
    rf_write_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [3:0]       dest_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] kill_q, occ, hit1, hit2;
    logic [AW:0]      wr_ptr, rd_ptr, count;
    logic [AW-1:0]    head, tail;
    logic [CW-1:0]    wait_cnt, wait_nxt;
    logic             empty, full, byp, push, pop, head_live, stall_q;
    assign head  = rd_ptr[AW-1:0];
    assign tail  = wr_ptr[AW-1:0];
    assign count = wr_ptr - rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (head == tail);
`ifdef RF_ARB_BYPASS_EN
    assign byp = empty && !bus.wb_en_a && bus.valid_b;
`else
    assign byp = 1'b0;
`endif
    assign push      = bus.valid_b && !full && !byp;
    assign pop       = !bus.wb_en_a && !empty;
    assign head_live = !kill_q[head];
    assign bus.ready_b     = !full;
    assign bus.stall_req   = stall_q;
    assign bus.writeBackEn = bus.wb_en_a || (pop && head_live) || byp;
    assign bus.Dest_wb     = bus.wb_en_a ? bus.dest_a : (pop && head_live) ? dest_q[head] : byp ? bus.dest_b : '0;
    assign bus.Result_WB   = bus.wb_en_a ? bus.result_a : (pop && head_live) ? data_q[head] : byp ? bus.result_b : '0;
    // Occupancy is measured as distance from the head so it stays valid across pointer wrap.
    always_comb begin
        occ  = '0;
        hit1 = '0;
        hit2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ[i]  = {1'b0, AW'(i) - head} < count;
            hit1[i] = dest_q[i] == bus.src1;
            hit2[i] = dest_q[i] == bus.src2;
        end
    end
    assign bus.pend_hit1 = |(occ & ~kill_q & hit1);
    assign bus.pend_hit2 = |(occ & ~kill_q & hit2);
    assign wait_nxt = (empty || pop) ? '0 : (wait_cnt == CW'(MAX_WAIT)) ? wait_cnt : wait_cnt + CW'(1);
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            kill_q   <= '0;
            wait_cnt <= '0;
            stall_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            // A newer A write to the same register kills stale B data, including one pushed this cycle.
            for (int i = 0; i < DEPTH; i++)
                kill_q[i] <= (push && tail == AW'(i)) ? (bus.wb_en_a && bus.dest_b == bus.dest_a)
                                                      : kill_q[i] || (bus.wb_en_a && dest_q[i] == bus.dest_a);
            wait_cnt <= wait_nxt;
            stall_q  <= wait_nxt == CW'(MAX_WAIT);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[tail] <= bus.dest_b;
            data_q[tail] <= bus.result_b;
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed scenario tasks with hand-computed expectations for rf_write_arbiter
module tb_rf_write_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int errors = 0;
    logic [31:0] rf_model [16];
    rf_write_arbiter_if bus();
    rf_write_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    always @(posedge clk) if (!rst && bus.writeBackEn) rf_model[bus.Dest_wb] <= bus.Result_WB;
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.wb_en_a = 0; bus.dest_a = 0; bus.result_a = 0;
        bus.valid_b = 0; bus.dest_b = 0; bus.result_b = 0;
        bus.src1 = 0; bus.src2 = 0;
    endtask
    task automatic test_reset();
        idle();
        rst = 1;
        cyc(); cyc();
        #1;
        vectors++;
        if ({bus.writeBackEn, bus.Dest_wb, bus.Result_WB} !== 37'd0) begin errors++;
            $display("FAIL reset_port: got %b/%0d/%h want 0/0/0", bus.writeBackEn, bus.Dest_wb, bus.Result_WB); end
        vectors++;
        if ({bus.ready_b, bus.stall_req, bus.pend_hit1, bus.pend_hit2} !== 4'b1000) begin errors++;
            $display("FAIL reset_flags: got %b%b%b%b want 1000", bus.ready_b, bus.stall_req, bus.pend_hit1, bus.pend_hit2); end
        rst = 0;
        for (int i = 0; i < 16; i++) rf_model[i] = 0;
        cyc();
    endtask
    task automatic test_single();
        idle();
        bus.valid_b = 1; bus.dest_b = 5; bus.result_b = 32'hAA;
        #1;
        vectors++;
`ifdef RF_ARB_BYPASS_EN
        if ({bus.writeBackEn, bus.Dest_wb, bus.Result_WB} !== {1'b1, 4'd5, 32'hAA}) begin errors++;
`else
        if ({bus.writeBackEn, bus.Dest_wb, bus.Result_WB} !== {1'b0, 4'd0, 32'h0}) begin errors++;
`endif
            $display("FAIL single_first: got %b/%0d/%h", bus.writeBackEn, bus.Dest_wb, bus.Result_WB); end
        cyc();
        bus.valid_b = 0;
        #1;
        vectors++;
`ifdef RF_ARB_BYPASS_EN
        if ({bus.writeBackEn, bus.Dest_wb, bus.Result_WB} !== {1'b0, 4'd0, 32'h0}) begin errors++;
`else
        if ({bus.writeBackEn, bus.Dest_wb, bus.Result_WB} !== {1'b1, 4'd5, 32'hAA}) begin errors++;
`endif
            $display("FAIL single_second: got %b/%0d/%h", bus.writeBackEn, bus.Dest_wb, bus.Result_WB); end
        cyc();
        vectors++;
        if (bus.writeBackEn !== 1'b0 || bus.ready_b !== 1'b1) begin errors++;
            $display("FAIL single_after: got wbe=%b ready=%b want 0 1", bus.writeBackEn, bus.ready_b); end
    endtask
    task automatic test_starve();
        idle();
        bus.wb_en_a = 1; bus.dest_a = 1; bus.result_a = 32'h5A;
        for (int i = 0; i < 4; i++) begin
            bus.valid_b = 1; bus.dest_b = 4'(8 + i); bus.result_b = 32'h100 + i;
            #1;
            vectors++;
            if (bus.ready_b !== 1'b1) begin errors++;
                $display("FAIL starve_ready%0d: got %b want 1", i, bus.ready_b); end
            cyc();
        end
        bus.valid_b = 0;
        #1;
        vectors++;
        if (bus.ready_b !== 1'b0) begin errors++;
            $display("FAIL starve_full: ready got %b want 0", bus.ready_b); end
        vectors++;
        if ({bus.writeBackEn, bus.Dest_wb, bus.Result_WB} !== {1'b1, 4'd1, 32'h5A}) begin errors++;
            $display("FAIL starve_a_prio: got %b/%0d/%h want 1/1/5a", bus.writeBackEn, bus.Dest_wb, bus.Result_WB); end
        repeat (4) cyc();
        vectors++;
        if (bus.stall_req !== 1'b0) begin errors++;
            $display("FAIL starve_early: stall got %b want 0", bus.stall_req); end
        cyc();
        vectors++;
        if (bus.stall_req !== 1'b1) begin errors++;
            $display("FAIL starve_stall: stall got %b want 1", bus.stall_req); end
        cyc();
        vectors++;
        if (bus.stall_req !== 1'b1) begin errors++;
            $display("FAIL starve_hold: stall got %b want 1", bus.stall_req); end
        bus.wb_en_a = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if ({bus.writeBackEn, bus.Dest_wb, bus.Result_WB} !== {1'b1, 4'(8 + i), 32'h100 + i}) begin errors++;
                $display("FAIL drain%0d: got %b/%0d/%h want 1/%0d/%h", i, bus.writeBackEn, bus.Dest_wb, bus.Result_WB, 8 + i, 32'h100 + i); end
            vectors++;
            if (bus.stall_req !== (i == 0)) begin errors++;
                $display("FAIL drain_stall%0d: got %b want %b", i, bus.stall_req, i == 0); end
            cyc();
        end
        vectors++;
        if (bus.writeBackEn !== 1'b0 || bus.ready_b !== 1'b1) begin errors++;
            $display("FAIL drain_done: wbe=%b ready=%b want 0 1", bus.writeBackEn, bus.ready_b); end
    endtask
    task automatic test_waw();
        idle();
        bus.wb_en_a = 1; bus.dest_a = 0; bus.result_a = 0;
        bus.valid_b = 1; bus.dest_b = 3; bus.result_b = 32'h11;
        cyc();
        bus.valid_b = 0; bus.dest_a = 3; bus.result_a = 32'h22; bus.src1 = 3;
        #1;
        vectors++;
        if (bus.pend_hit1 !== 1'b1) begin errors++;
            $display("FAIL waw_pend_live: got %b want 1", bus.pend_hit1); end
        cyc();
        bus.wb_en_a = 0;
        #1;
        vectors++;
        if (bus.writeBackEn !== 1'b0 || bus.pend_hit1 !== 1'b0) begin errors++;
            $display("FAIL waw_killed_pop: wbe=%b pend=%b want 0 0", bus.writeBackEn, bus.pend_hit1); end
        cyc();
        vectors++;
        if (rf_model[3] !== 32'h22) begin errors++;
            $display("FAIL waw_r3: got %h want 22", rf_model[3]); end
        bus.wb_en_a = 1; bus.dest_a = 6; bus.result_a = 32'h66;
        bus.valid_b = 1; bus.dest_b = 6; bus.result_b = 32'h99;
        cyc();
        idle();
        #1;
        vectors++;
        if (bus.writeBackEn !== 1'b0) begin errors++;
            $display("FAIL waw_same_cycle: wbe got %b want 0", bus.writeBackEn); end
        cyc();
        vectors++;
        if (rf_model[6] !== 32'h66 || bus.ready_b !== 1'b1) begin errors++;
            $display("FAIL waw_r6: got %h ready=%b want 66 1", rf_model[6], bus.ready_b); end
    endtask
    task automatic test_pend();
        idle();
        bus.wb_en_a = 1; bus.dest_a = 0;
        bus.valid_b = 1; bus.dest_b = 7; bus.result_b = 32'h77;
        cyc();
        bus.valid_b = 0; bus.src1 = 7; bus.src2 = 2;
        #1;
        vectors++;
        if ({bus.pend_hit1, bus.pend_hit2} !== 2'b10) begin errors++;
            $display("FAIL pend_hit: got %b%b want 10", bus.pend_hit1, bus.pend_hit2); end
        bus.src2 = 7;
        #1;
        vectors++;
        if ({bus.pend_hit1, bus.pend_hit2} !== 2'b11) begin errors++;
            $display("FAIL pend_hit2: got %b%b want 11", bus.pend_hit1, bus.pend_hit2); end
        bus.wb_en_a = 0; bus.src2 = 2;
        cyc();
        vectors++;
        if ({bus.pend_hit1, bus.pend_hit2} !== 2'b00 || rf_model[7] !== 32'h77) begin errors++;
            $display("FAIL pend_drained: got %b%b r7=%h want 00 77", bus.pend_hit1, bus.pend_hit2, rf_model[7]); end
    endtask
    task automatic test_reset_flush();
        idle();
        bus.wb_en_a = 1; bus.dest_a = 0;
        for (int i = 0; i < 3; i++) begin
            bus.valid_b = 1; bus.dest_b = 4'(12 + i); bus.result_b = 32'hC0 + i;
            cyc();
        end
        bus.valid_b = 0; bus.src1 = 12;
        #1;
        vectors++;
        if (bus.pend_hit1 !== 1'b1) begin errors++;
            $display("FAIL flush_pre: pend got %b want 1", bus.pend_hit1); end
        bus.wb_en_a = 0;
        rst = 1;
        cyc();
        rst = 0;
        #1;
        vectors++;
        if ({bus.ready_b, bus.writeBackEn, bus.pend_hit1, bus.stall_req} !== 4'b1000) begin errors++;
            $display("FAIL flush_post: ready/wbe/pend/stall got %b%b%b%b want 1000", bus.ready_b, bus.writeBackEn, bus.pend_hit1, bus.stall_req); end
        cyc();
        vectors++;
        if (bus.writeBackEn !== 1'b0 || rf_model[12] !== 32'h0) begin errors++;
            $display("FAIL flush_nowrite: wbe=%b r12=%h want 0 0", bus.writeBackEn, rf_model[12]); end
    endtask
    initial begin
        test_reset();
        test_single();
        test_starve();
        test_waw();
        test_pend();
        test_reset_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
